// File: rtl/osd_ctl_pkg.sv
// Shared constants and state encoding for the OSD SPI command sequencer.
package osd_ctl_pkg;

   localparam logic [7:0]  OSD_CMD_WRITE  = 8'h20;
   localparam logic [7:0]  OSD_CMD_ENABLE = 8'h40;
   localparam int unsigned OSD_LINE_BYTES = 256;

   typedef enum logic [2:0] {IDLE, START, SHIFT, TAIL, GAP} osd_state_t;

endpackage

// File: rtl/osd_spi_tx.sv
// Byte serializer for the OSD SPI port: MSB first, DI changes with SCK falling, SCK idles low.
module osd_spi_tx #(
   parameter int unsigned SCK_DIV = 4
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] byte_in,
   output logic       need_next,
   output logic       byte_done,
   output logic       sck,
   output logic       di
);

   localparam logic [7:0] DIV_LAST = 8'(SCK_DIV - 1);
   localparam logic [7:0] DIV_PRE  = 8'(SCK_DIV - 2);

   logic [7:0] sh;
   logic [7:0] div;
   logic [2:0] bit_cnt;
   logic       active;
   logic       pre;
   logic       half_end;

   assign half_end  = active && !pre && (div == DIV_LAST);
   assign byte_done = half_end && sck && (bit_cnt == 3'd7);
   // One cycle ahead of the final low-half cycle of the last bit, so a RAM read lands in time.
   assign need_next = active && !pre && !sck && (div == DIV_PRE) && (bit_cnt == 3'd7);

   // A load while idle starts a frame with one extra lead-in cycle; a load at byte_done chains seamlessly.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sh      <= 8'd0;
         div     <= 8'd0;
         bit_cnt <= 3'd0;
         active  <= 1'b0;
         pre     <= 1'b0;
         sck     <= 1'b0;
         di      <= 1'b0;
      end else if (load && !active) begin
         active  <= 1'b1;
         pre     <= 1'b1;
         sh      <= byte_in;
         di      <= byte_in[7];
         bit_cnt <= 3'd0;
         div     <= 8'd0;
         sck     <= 1'b0;
      end else if (active) begin
         if (pre) begin
            pre <= 1'b0;
         end else if (half_end) begin
            div <= 8'd0;
            if (!sck) begin
               sck <= 1'b1;
            end else begin
               sck <= 1'b0;
               if (bit_cnt == 3'd7) begin
                  if (load) begin
                     sh      <= byte_in;
                     di      <= byte_in[7];
                     bit_cnt <= 3'd0;
                  end else begin
                     active <= 1'b0;
                     di     <= 1'b0;
                  end
               end else begin
                  sh      <= {sh[6:0], 1'b0};
                  di      <= sh[6];
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end
         end else begin
            div <= div + 8'd1;
         end
      end
   end

endmodule

// File: rtl/osd_cmd_sequencer.sv
// Arbitrates enable and line-write requests, builds OSD command frames and streams line RAM data.
module osd_cmd_sequencer #(
   parameter int unsigned SCK_DIV    = 4,
   parameter int unsigned GAP_HALVES = 2
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       en_req,
   input  logic       en_val,
   output logic       en_ack,
   input  logic       wr_req,
   input  logic [2:0] wr_line,
   output logic       wr_ack,
   output logic [7:0] rd_addr,
   output logic       rd_en,
   input  logic [7:0] rd_data,
   output logic       busy,
   output logic       SPI_SCK,
   output logic       SPI_SS3,
   output logic       SPI_DI
);

   import osd_ctl_pkg::*;

   localparam int unsigned HW        = $clog2(GAP_HALVES + 1);
   localparam logic [7:0]  DIV_LAST  = 8'(SCK_DIV - 1);
   localparam logic [HW-1:0] GAP_LAST = HW'(GAP_HALVES - 1);
   localparam logic [8:0]  BYTES_END = 9'(OSD_LINE_BYTES);

   osd_state_t  state;
   logic        kind_wr;
   logic        prio_wr;
   logic        have_next;
   logic        rd_pend;
   logic [7:0]  cnt;
   logic [7:0]  next_byte;
   logic [HW-1:0] halves;
   logic [8:0]  byte_cnt;

   logic        any_req;
   logic        pick_wr;
   logic        gap_end;
   logic        launch;
   logic        fetch;
   logic        tx_load;
   logic        tx_need_next;
   logic        tx_byte_done;
   logic [7:0]  cmd;
   logic [7:0]  tx_byte;

   assign any_req = en_req | wr_req;
   assign pick_wr = wr_req & (~en_req | prio_wr);
   assign cmd     = pick_wr ? (OSD_CMD_WRITE | {5'd0, wr_line}) : (OSD_CMD_ENABLE | {7'd0, en_val});
   // The final gap cycle doubles as the idle decision so back-to-back frames see exactly the gap.
   assign gap_end = (state == GAP) && (cnt == DIV_LAST) && (halves == GAP_LAST);
   assign launch  = any_req && ((state == IDLE) || gap_end);
   assign fetch   = (state == SHIFT) && kind_wr && tx_need_next && (byte_cnt != BYTES_END);
   assign tx_load = launch || (tx_byte_done && have_next);
   assign tx_byte = launch ? cmd : next_byte;

   osd_spi_tx #(.SCK_DIV(SCK_DIV)) u_tx (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .load      (tx_load),
      .byte_in   (tx_byte),
      .need_next (tx_need_next),
      .byte_done (tx_byte_done),
      .sck       (SPI_SCK),
      .di        (SPI_DI)
   );

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state     <= IDLE;
         SPI_SS3   <= 1'b1;
         busy      <= 1'b0;
         en_ack    <= 1'b0;
         wr_ack    <= 1'b0;
         rd_en     <= 1'b0;
         rd_addr   <= 8'd0;
         rd_pend   <= 1'b0;
         have_next <= 1'b0;
         next_byte <= 8'd0;
         byte_cnt  <= 9'd0;
         kind_wr   <= 1'b0;
         prio_wr   <= 1'b0;
         cnt       <= 8'd0;
         halves    <= '0;
      end else begin
         en_ack  <= 1'b0;
         wr_ack  <= 1'b0;
         rd_en   <= fetch;
         rd_pend <= rd_en;
         if (fetch) begin
            rd_addr  <= byte_cnt[7:0];
            byte_cnt <= byte_cnt + 9'd1;
         end
         // RAM data is valid the cycle after the strobe.
         if (rd_pend) begin
            next_byte <= rd_data;
            have_next <= 1'b1;
         end else if (tx_byte_done && have_next) begin
            have_next <= 1'b0;
         end

         if (launch) begin
            state     <= START;
            SPI_SS3   <= 1'b0;
            busy      <= 1'b1;
            kind_wr   <= pick_wr;
            byte_cnt  <= 9'd0;
            have_next <= 1'b0;
         end else begin
            case (state)
               IDLE: ;
               START: state <= SHIFT;
               SHIFT: begin
                  if (tx_byte_done && !have_next) begin
                     state <= TAIL;
                     cnt   <= 8'd0;
                  end
               end
               TAIL: begin
                  if (cnt == DIV_LAST) begin
                     state   <= GAP;
                     SPI_SS3 <= 1'b1;
                     cnt     <= 8'd0;
                     halves  <= '0;
                     wr_ack  <= kind_wr;
                     en_ack  <= !kind_wr;
                     prio_wr <= !kind_wr;
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
               GAP: begin
                  if (cnt == DIV_LAST) begin
                     cnt <= 8'd0;
                     if (halves == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end else begin
                        halves <= halves + HW'(1);
                     end
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_osd_cmd_sequencer.sv
// Directed self-checking bench for osd_cmd_sequencer with SCK_DIV=2, GAP_HALVES=2.
module tb_osd_cmd_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en_req = 1'b0;
   logic       en_val = 1'b0;
   logic       en_ack;
   logic       wr_req = 1'b0;
   logic [2:0] wr_line = 3'd0;
   logic       wr_ack;
   logic [7:0] rd_addr;
   logic       rd_en;
   logic [7:0] rd_data = 8'd0;
   logic       busy;
   logic       SPI_SCK;
   logic       SPI_SS3;
   logic       SPI_DI;

   int tests = 0;
   int fails = 0;

   osd_cmd_sequencer #(.SCK_DIV(2), .GAP_HALVES(2)) dut (
      .clk_sys (clk),
      .reset   (reset),
      .en_req  (en_req),
      .en_val  (en_val),
      .en_ack  (en_ack),
      .wr_req  (wr_req),
      .wr_line (wr_line),
      .wr_ack  (wr_ack),
      .rd_addr (rd_addr),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .busy    (busy),
      .SPI_SCK (SPI_SCK),
      .SPI_SS3 (SPI_SS3),
      .SPI_DI  (SPI_DI)
   );

   always #5 clk = ~clk;

   // Line RAM: one-cycle read latency, contents addr ^ 0xA5.
   always @(posedge clk) if (rd_en) rd_data <= rd_addr ^ 8'hA5;

   typedef struct {
      logic [7:0] cmd;
      int         nbytes;
      int         low_len;
      int         high_before;
      logic [1:0] ack;
   } frame_t;

   frame_t     log_q[$];
   frame_t     fr;
   logic [7:0] cur_q[$];
   logic [7:0] last_q[$];
   logic       ss3_p = 1'b1;
   logic       sck_p = 1'b0;
   logic       busy_p = 1'b0;
   logic [7:0] mon_sh = 8'd0;
   int cyc = 0, low_len = 0, high_len = 0, high_before_cur = 0, sck_low_run = 0;
   int rises = 0, bitn = 0, en_ack_n = 0, wr_ack_n = 0, stray_ack = 0;
   int rd_n = 0, rd_exp = 0, rd_addr_err = 0, gap_err = 0, last_rise_cyc = 0, busy_fall_delay = -1;

   // Bus monitor: decodes frames on SCK rising edges and records timing.
   always @(negedge clk) begin
      cyc++;
      if (en_ack) en_ack_n++;
      if (wr_ack) wr_ack_n++;
      if ((en_ack || wr_ack) && !(SPI_SS3 && !ss3_p)) stray_ack++;
      if (rd_en) begin
         rd_n++;
         if (rd_addr !== 8'(rd_exp)) rd_addr_err++;
         rd_exp++;
      end
      if (!SPI_SS3) begin
         if (ss3_p) begin
            high_before_cur = high_len;
            low_len = 0; rises = 0; bitn = 0; rd_exp = 0; sck_low_run = 0;
            cur_q.delete();
         end
         low_len++;
         if (SPI_SCK && !sck_p) begin
            if (rises > 0 && sck_low_run != 2) gap_err++;
            rises++;
            mon_sh = {mon_sh[6:0], SPI_DI};
            bitn++;
            if (bitn == 8) begin
               cur_q.push_back(mon_sh);
               bitn = 0;
            end
         end
         if (!SPI_SCK) sck_low_run++; else sck_low_run = 0;
      end else begin
         if (!ss3_p) begin
            fr.cmd = (cur_q.size() > 0) ? cur_q[0] : 8'hxx;
            fr.nbytes = cur_q.size();
            fr.low_len = low_len;
            fr.high_before = high_before_cur;
            fr.ack = {wr_ack, en_ack};
            log_q.push_back(fr);
            last_q = cur_q;
            last_rise_cyc = cyc;
            high_len = 0;
         end
         high_len++;
      end
      if (!busy && busy_p) busy_fall_delay = cyc - last_rise_cyc;
      ss3_p = SPI_SS3; sck_p = SPI_SCK; busy_p = busy;
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input bit wr, input int budget, output bit ok);
      int n0;
      n0 = wr ? wr_ack_n : en_ack_n;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step;
         if ((wr ? wr_ack_n : en_ack_n) != n0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; en_req = 1'b0; wr_req = 1'b0;
      repeat (3) step;
      tests++;
      if ({SPI_SS3, SPI_SCK, SPI_DI, en_ack, wr_ack, rd_en, rd_addr, busy} !== {6'b100000, 8'd0, 1'b0})
         begin fails++; $display("FAIL reset_outputs got ss3/sck/di/eack/wack/rden=%b%b%b%b%b%b addr=%0d busy=%b", SPI_SS3, SPI_SCK, SPI_DI, en_ack, wr_ack, rd_en, rd_addr, busy); end
      reset = 1'b0;
      step;
   endtask

   task automatic test_enable(input logic val);
      int l0, e0, r0;
      bit ok;
      frame_t f;
      logic [7:0] exp_cmd;
      l0 = log_q.size(); e0 = en_ack_n; r0 = rd_n;
      exp_cmd = 8'h40 | {7'd0, val};
      en_val = val; en_req = 1'b1;
      wait_ack(1'b0, 200, ok);
      en_req = 1'b0;
      repeat (8) step;
      tests++;
      if (ok !== 1'b1) begin fails++; $display("FAIL enable_ack_timeout val=%b", val); end
      tests++;
      if (log_q.size() != l0 + 1) begin fails++; $display("FAIL enable_frame_count got %0d want %0d", log_q.size() - l0, 1); end
      if (log_q.size() > l0) begin
         f = log_q[l0];
         tests++;
         if (f.cmd !== exp_cmd || f.nbytes != 1) begin fails++; $display("FAIL enable_cmd got %h (%0d bytes) want %h (1 byte)", f.cmd, f.nbytes, exp_cmd); end
         tests++;
         if (f.low_len != 35) begin fails++; $display("FAIL enable_ss3_low got %0d want 35", f.low_len); end
         tests++;
         if (f.ack !== 2'b01) begin fails++; $display("FAIL enable_ack_at_ss3_rise got %b want 01", f.ack); end
      end
      tests++;
      if (en_ack_n - e0 != 1) begin fails++; $display("FAIL enable_ack_count got %0d want 1", en_ack_n - e0); end
      tests++;
      if (busy_fall_delay != 4) begin fails++; $display("FAIL enable_busy_delay got %0d want 4", busy_fall_delay); end
      tests++;
      if (rd_n != r0) begin fails++; $display("FAIL enable_no_reads got %0d want 0", rd_n - r0); end
   endtask

   task automatic test_write;
      int l0, w0, r0, a0, derr;
      bit ok;
      frame_t f;
      l0 = log_q.size(); w0 = wr_ack_n; r0 = rd_n; a0 = rd_addr_err; derr = 0;
      wr_line = 3'd5; wr_req = 1'b1;
      wait_ack(1'b1, 9000, ok);
      wr_req = 1'b0;
      repeat (8) step;
      tests++;
      if (ok !== 1'b1) begin fails++; $display("FAIL write_ack_timeout"); end
      tests++;
      if (log_q.size() != l0 + 1) begin fails++; $display("FAIL write_frame_count got %0d want 1", log_q.size() - l0); end
      if (log_q.size() > l0) begin
         f = log_q[l0];
         tests++;
         if (f.cmd !== 8'h25 || f.nbytes != 257) begin fails++; $display("FAIL write_cmd got %h (%0d bytes) want 25 (257 bytes)", f.cmd, f.nbytes); end
         tests++;
         if (f.low_len != 8227) begin fails++; $display("FAIL write_ss3_low got %0d want 8227", f.low_len); end
         tests++;
         if (f.ack !== 2'b10) begin fails++; $display("FAIL write_ack_at_ss3_rise got %b want 10", f.ack); end
      end
      for (int i = 1; i < last_q.size(); i++)
         if (last_q[i] !== (8'(i - 1) ^ 8'hA5)) derr++;
      tests++;
      if (derr != 0 || last_q.size() != 257) begin fails++; $display("FAIL write_data got %0d bad bytes of %0d want 0 of 257", derr, last_q.size()); end
      tests++;
      if (rd_n - r0 != 256 || rd_addr_err != a0) begin fails++; $display("FAIL write_reads got %0d strobes %0d bad addrs want 256 0", rd_n - r0, rd_addr_err - a0); end
      tests++;
      if (gap_err != 0) begin fails++; $display("FAIL write_sck_gap got %0d irregular low halves want 0", gap_err); end
      tests++;
      if (wr_ack_n - w0 != 1) begin fails++; $display("FAIL write_ack_count got %0d want 1", wr_ack_n - w0); end
   endtask

   task automatic test_arbitration;
      int l0, e0, w0;
      bit done;
      test_reset;
      l0 = log_q.size(); e0 = en_ack_n; w0 = wr_ack_n; done = 1'b0;
      en_val = 1'b0; wr_line = 3'd3;
      en_req = 1'b1; wr_req = 1'b1;
      for (int i = 0; i < 10000 && !done; i++) begin
         step;
         if (en_ack_n != e0) en_req = 1'b0;
         if (wr_ack_n != w0) wr_req = 1'b0;
         done = !en_req && !wr_req;
      end
      en_req = 1'b0; wr_req = 1'b0;
      repeat (8) step;
      tests++;
      if (log_q.size() != l0 + 2) begin fails++; $display("FAIL arb_frame_count got %0d want 2", log_q.size() - l0); end
      if (log_q.size() >= l0 + 2) begin
         tests++;
         if (log_q[l0].cmd !== 8'h40 || log_q[l0 + 1].cmd !== 8'h23) begin fails++; $display("FAIL arb_order got %h,%h want 40,23", log_q[l0].cmd, log_q[l0 + 1].cmd); end
         tests++;
         if (log_q[l0 + 1].high_before != 4) begin fails++; $display("FAIL arb_gap got %0d want 4", log_q[l0 + 1].high_before); end
      end
   endtask

   task automatic test_back_to_back;
      int l0;
      logic [7:0] exp_cmd [4];
      exp_cmd = '{8'h41, 8'h27, 8'h41, 8'h27};
      l0 = log_q.size();
      en_val = 1'b1; wr_line = 3'd7;
      en_req = 1'b1; wr_req = 1'b1;
      for (int i = 0; i < 20000 && log_q.size() < l0 + 4; i++) step;
      en_req = 1'b0; wr_req = 1'b0;
      repeat (8) step;
      tests++;
      if (log_q.size() != l0 + 4) begin fails++; $display("FAIL alt_frame_count got %0d want 4", log_q.size() - l0); end
      if (log_q.size() >= l0 + 4) begin
         for (int k = 0; k < 4; k++) begin
            tests++;
            if (log_q[l0 + k].cmd !== exp_cmd[k]) begin fails++; $display("FAIL alt_cmd_%0d got %h want %h", k, log_q[l0 + k].cmd, exp_cmd[k]); end
         end
         for (int k = 1; k < 4; k++) begin
            tests++;
            if (log_q[l0 + k].high_before != 4) begin fails++; $display("FAIL alt_gap_%0d got %0d want 4", k, log_q[l0 + k].high_before); end
         end
      end
   endtask

   task automatic test_late_changes;
      int l0, e0, w0;
      bit done;
      l0 = log_q.size(); e0 = en_ack_n; w0 = wr_ack_n; done = 1'b0;
      wr_line = 3'd5; en_val = 1'b0; wr_req = 1'b1;
      for (int i = 0; i < 500 && !(SPI_SS3 === 1'b0 && rises >= 20); i++) step;
      wr_line = 3'd2; en_val = 1'b1; en_req = 1'b1;
      for (int i = 0; i < 10000 && !done; i++) begin
         step;
         if (en_ack_n != e0) en_req = 1'b0;
         if (wr_ack_n != w0) wr_req = 1'b0;
         done = !en_req && !wr_req;
      end
      en_req = 1'b0; wr_req = 1'b0;
      repeat (8) step;
      tests++;
      if (log_q.size() != l0 + 2) begin fails++; $display("FAIL late_frame_count got %0d want 2", log_q.size() - l0); end
      if (log_q.size() >= l0 + 2) begin
         tests++;
         if (log_q[l0].cmd !== 8'h25) begin fails++; $display("FAIL late_wr_line got %h want 25", log_q[l0].cmd); end
         tests++;
         if (log_q[l0 + 1].cmd !== 8'h41 || log_q[l0 + 1].high_before != 4) begin fails++; $display("FAIL late_en_after_gap got %h gap %0d want 41 gap 4", log_q[l0 + 1].cmd, log_q[l0 + 1].high_before); end
      end
   endtask

   task automatic test_reset_mid;
      int l0, w0, derr;
      bit ok;
      l0 = log_q.size(); w0 = wr_ack_n; derr = 0;
      wr_line = 3'd5; wr_req = 1'b1;
      for (int i = 0; i < 2000 && !(SPI_SS3 === 1'b0 && rises >= 100); i++) step;
      reset = 1'b1;
      step;
      tests++;
      if ({SPI_SS3, SPI_SCK} !== 2'b10) begin fails++; $display("FAIL rst_mid_lines got ss3=%b sck=%b want 1 0", SPI_SS3, SPI_SCK); end
      reset = 1'b0;
      step;
      tests++;
      if (wr_ack_n != w0) begin fails++; $display("FAIL rst_mid_no_ack got %0d acks want 0", wr_ack_n - w0); end
      wait_ack(1'b1, 9000, ok);
      wr_req = 1'b0;
      repeat (8) step;
      tests++;
      if (ok !== 1'b1 || wr_ack_n - w0 != 1) begin fails++; $display("FAIL rst_mid_restart_ack got %0d acks want 1", wr_ack_n - w0); end
      tests++;
      if (log_q.size() != l0 + 2) begin fails++; $display("FAIL rst_mid_frames got %0d want 2", log_q.size() - l0); end
      if (log_q.size() >= l0 + 2) begin
         tests++;
         if (log_q[l0].ack !== 2'b00) begin fails++; $display("FAIL rst_mid_abort_ack got %b want 00", log_q[l0].ack); end
         tests++;
         if (log_q[l0 + 1].cmd !== 8'h25 || log_q[l0 + 1].nbytes != 257 || log_q[l0 + 1].low_len != 8227)
            begin fails++; $display("FAIL rst_mid_full_frame got %h %0d bytes %0d low want 25 257 8227", log_q[l0 + 1].cmd, log_q[l0 + 1].nbytes, log_q[l0 + 1].low_len); end
      end
      for (int i = 1; i < last_q.size(); i++)
         if (last_q[i] !== (8'(i - 1) ^ 8'hA5)) derr++;
      tests++;
      if (derr != 0 || last_q.size() != 257) begin fails++; $display("FAIL rst_mid_data got %0d bad of %0d want 0 of 257", derr, last_q.size()); end
   endtask

   task automatic test_idle;
      int viol;
      viol = 0;
      repeat (1000) begin
         step;
         if (SPI_SS3 !== 1'b1 || SPI_SCK !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) viol++;
      end
      tests++;
      if (viol != 0) begin fails++; $display("FAIL idle_quiet got %0d bad cycles want 0", viol); end
      tests++;
      if (stray_ack != 0) begin fails++; $display("FAIL stray_acks got %0d want 0", stray_ack); end
   endtask

   initial begin
      test_reset;
      test_enable(1'b1);
      test_enable(1'b0);
      test_write;
      test_arbitration;
      test_back_to_back;
      test_late_changes;
      test_reset_mid;
      test_idle;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/osd_cmd_sequencer.md
Name: osd_cmd_sequencer

Overview:
- Core-side master for the OSD overlay's 3-wire SPI port (SCK / SS3 / DI).
- Arbitrates between two requesters, builds complete OSD command frames, and drives them bit-serially:
  - OSD enable/disable requester.
  - Line-write requester, which streams 256 bytes from a local line RAM.
- Lets a core draw or toggle its own OSD without the IO controller.

Parameters:
- SCK_DIV, 4: clk_sys cycles per SCK half-period. Legal range is 2..255.
- GAP_HALVES, 2: SS3-high idle time between frames, in SCK half-periods. Must be at least 1.

Ports:
- clk_sys  in  1  system clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- en_req  in  1  enable-command request, level. Held until en_ack.
- en_val  in  1  1 = OSD enable, 0 = disable. Sampled at frame start.
- en_ack  out  1  one-cycle pulse when the enable frame completes.
- wr_req  in  1  line-write request, level. Held until wr_ack.
- wr_line  in  3  OSD line (0..7) to write. Sampled at frame start.
- wr_ack  out  1  one-cycle pulse when the write frame completes.
- rd_addr  out  8  byte address into the requester's line RAM.
- rd_en  out  1  read strobe.
- rd_data  in  8  RAM data. Valid exactly 1 cycle after rd_en.
- busy  out  1  high from frame start through the end of the inter-frame gap.
- SPI_SCK  out  1  serial clock, idle low.
- SPI_SS3  out  1  frame select, active low, idle high.
- SPI_DI  out  1  serial data, MSB first.

Behaviour:
- Reset values:
  - SPI_SS3=1, SPI_SCK=0, SPI_DI=0.
  - en_ack=0, wr_ack=0, rd_en=0, rd_addr=0, busy=0.
  - State IDLE.
  - Round-robin pointer favours the enable requester.
- States: IDLE -> START -> SHIFT -> TAIL -> GAP -> IDLE.
- IDLE:
  - If any request is pending, select a winner, latch en_val or wr_line, and go to START.
  - Drive SS3=0 and busy=1 in the same cycle as the transition.
- Arbitration (round-robin):
  - If both requests are pending, the requester not served last wins.
  - The pointer updates when a frame completes.
  - A request that appears mid-frame waits for IDLE.
- Command byte:
  - Enable frame: 0x40 | en_val, 8 bits total.
  - Write frame: 0x20 | wr_line, followed by bytes 0..255 from RAM. Total 8 + 2048 bits.
- Bit timing:
  - Each bit lasts 2*SCK_DIV cycles.
  - DI updates on the first cycle of the low half.
  - SCK rises after SCK_DIV cycles and falls after 2*SCK_DIV cycles.
  - The OSD samples DI on SCK rising.
- START: a single cycle; presents command bit 7 on DI.
- Data fetch:
  - Assert rd_en with rd_addr=k during the last low-half cycle of bit 0 of the preceding byte.
  - Capture rd_data in the next cycle into the next-byte register.
  - Byte-to-byte transitions therefore have zero SCK gap.
  - rd_addr increments 0..255 with no wrap. 256 rd_en pulses per write frame, none for enable frames.
- TAIL:
  - After the final SCK falling edge, hold SS3=0 and SCK=0 for SCK_DIV cycles, then set SS3=1.
  - The matching ack pulses in the cycle SS3 rises.
- SS3 low duration: N*2*SCK_DIV + 1 + SCK_DIV cycles, where N is the frame's bit count.
- GAP:
  - SS3 stays high for GAP_HALVES*SCK_DIV cycles.
  - busy drops on the cycle IDLE is re-entered.
  - Back-to-back frames are therefore separated by exactly that gap.
- Requester rules:
  - Changes to en_val, wr_line or rd_data outside their sample points are ignored.
  - Dropping a request before its ack is a protocol violation. The frame in flight still completes and still acks.
- Reset mid-frame: the next cycle is IDLE with SS3=1. No ack is issued and the pending request is not lost. The OSD side discards the partial frame.
- Counters:
  - Bit counter: 3 bits.
  - Byte counter: 9 bits (0..256).
  - Divider: 8 bits.
  - No arithmetic overflow is possible within the legal parameter range.

Decomposition:
- Package osd_ctl_pkg holds:
  - OSD_CMD_WRITE = 8'h20 and OSD_CMD_ENABLE = 8'h40.
  - OSD_LINE_BYTES = 256.
  - The state enum (IDLE, START, SHIFT, TAIL, GAP).
- Sub-module osd_spi_tx: byte serializer with SCK divider.
  - Inputs: load, byte in.
  - Outputs: need_next (1 cycle before the last low half), byte_done, SCK, DI.
- osd_cmd_sequencer contains the arbiter, FSM and RAM fetch logic.

Test Plan (all with SCK_DIV=2, GAP_HALVES=2):
- Enable frame: en_req=1, en_val=1.
  - DI sampled on 8 SCK rising edges = 0x41.
  - SS3 low for 35 cycles.
  - en_ack pulses once, exactly as SS3 rises.
  - busy deasserts 4 cycles later.
  - Repeat with en_val=0 -> 0x40.
- Line write: wr_req=1, wr_line=5, RAM model returns addr^0xA5.
  - Stream is 0x25 followed by 0xA5, 0xA4, ... 0x5A (257 bytes).
  - rd_addr sequence is 0..255, 256 rd_en pulses.
  - No SCK gap between bytes.
  - SS3 low for 8227 cycles.
  - Exactly one wr_ack.
- Arbitration: en_req and wr_req rise in the same cycle out of reset.
  - Enable frame first, then write frame after a 4-cycle SS3-high gap.
  - Repeat with both held: frames alternate.
- Late changes: toggle wr_line to 2 mid-frame -> command byte stays 0x25. Assert en_req mid-frame -> it is served only after GAP.
- Reset at bit 100 of a write frame:
  - SS3=1, SCK=0 on the next cycle; no wr_ack.
  - The held wr_req restarts a full frame from byte 0.
- Idle: no requests for 1000 cycles -> SS3=1, SCK=0, rd_en=0, busy=0 throughout.
